// File: rtl/keypad_scanner_if.sv
// Keypad matrix lines and the digit pair handed to the seven-segment multiplexer.
// master = scanner side, slave = keypad/display side.
interface keypad_scanner_if;
  logic [3:0] col;
  logic [3:0] row;
  logic [3:0] digit_old;
  logic [3:0] digit_new;
  logic       key_pulse;

  modport master (
    input  col,
    output row,
    output digit_old,
    output digit_new,
    output key_pulse
  );

  modport slave (
    output col,
    input  row,
    input  digit_old,
    input  digit_new,
    input  key_pulse
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner with press/release debounce; keeps the last two digits.
// Press accepted DEBOUNCE_COUNT+3 cycles after a stable raw low; no backpressure, all outputs registered.
module keypad_scanner #(
  parameter int SCAN_COUNT     = 1_000,
  parameter int DEBOUNCE_COUNT = 500_000
) (
  input  logic              clk,
  input  logic              reset,
  keypad_scanner_if.master  kp
);

  localparam int SCW = (SCAN_COUNT > 1) ? $clog2(SCAN_COUNT) : 1;
  localparam int DBW = (DEBOUNCE_COUNT > 1) ? $clog2(DEBOUNCE_COUNT) : 1;
  localparam logic [SCW-1:0] SCAN_LAST  = SCW'(SCAN_COUNT - 1);
  localparam logic [SCW-1:0] SCAN_VALID = SCW'(2);
  localparam logic [DBW-1:0] DB_LAST    = DBW'(DEBOUNCE_COUNT - 1);

  typedef enum logic [1:0] {
    SCAN,
    PRESS_DB,
    HELD,
    RELEASE_DB
  } state_t;

  state_t         state_q;
  logic [3:0]     sync1_q;
  logic [3:0]     cs_q;
  logic [1:0]     row_idx_q;
  logic [3:0]     row_q;
  logic [SCW-1:0] scan_cnt_q;
  logic [DBW-1:0] db_cnt_q;
  logic [1:0]     key_row_q;
  logic [3:0]     key_cols_q;
  logic [3:0]     digit_old_q;
  logic [3:0]     digit_new_q;
  logic           key_pulse_q;
  logic [3:0]     key_digit;

  function automatic logic one_low(input logic [3:0] v);
    return $countones(~v) == 1;
  endfunction

  function automatic logic [3:0] row_drive(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

  function automatic logic [1:0] col_index(input logic [3:0] cols);
    logic [1:0] c;
    case (cols)
      4'b1110: c = 2'd0;
      4'b1101: c = 2'd1;
      4'b1011: c = 2'd2;
      4'b0111: c = 2'd3;
      default: c = 2'd0;
    endcase
    return c;
  endfunction

  // Physical layout: row 3 carries E 0 F D, so the map is not a plain index.
  always_comb begin
    key_digit = 4'h0;
    case ({key_row_q, col_index(key_cols_q)})
      4'h0: key_digit = 4'h1;
      4'h1: key_digit = 4'h2;
      4'h2: key_digit = 4'h3;
      4'h3: key_digit = 4'hA;
      4'h4: key_digit = 4'h4;
      4'h5: key_digit = 4'h5;
      4'h6: key_digit = 4'h6;
      4'h7: key_digit = 4'hB;
      4'h8: key_digit = 4'h7;
      4'h9: key_digit = 4'h8;
      4'hA: key_digit = 4'h9;
      4'hB: key_digit = 4'hC;
      4'hC: key_digit = 4'hE;
      4'hD: key_digit = 4'h0;
      4'hE: key_digit = 4'hF;
      4'hF: key_digit = 4'hD;
      default: key_digit = 4'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SCAN;
      sync1_q     <= 4'hF;
      cs_q        <= 4'hF;
      row_idx_q   <= 2'd0;
      row_q       <= 4'b1110;
      scan_cnt_q  <= '0;
      db_cnt_q    <= '0;
      key_row_q   <= 2'd0;
      key_cols_q  <= 4'hF;
      digit_old_q <= 4'h0;
      digit_new_q <= 4'h0;
      key_pulse_q <= 1'b0;
    end else begin
      sync1_q     <= kp.col;
      cs_q        <= sync1_q;
      key_pulse_q <= 1'b0;

      case (state_q)
        SCAN: begin
          // The first two counts still carry columns sampled under the previous row.
          if (scan_cnt_q >= SCAN_VALID && one_low(cs_q)) begin
            key_row_q  <= row_idx_q;
            key_cols_q <= cs_q;
            db_cnt_q   <= '0;
            state_q    <= PRESS_DB;
          end else if (scan_cnt_q == SCAN_LAST) begin
            row_idx_q  <= row_idx_q + 2'd1;
            row_q      <= row_drive(row_idx_q + 2'd1);
            scan_cnt_q <= '0;
          end else begin
            scan_cnt_q <= scan_cnt_q + SCW'(1);
          end
        end

        PRESS_DB: begin
          if (cs_q != key_cols_q) begin
            db_cnt_q   <= '0;
            scan_cnt_q <= '0;
            state_q    <= SCAN;
          end else if (db_cnt_q == DB_LAST) begin
            digit_old_q <= digit_new_q;
            digit_new_q <= key_digit;
            key_pulse_q <= 1'b1;
            state_q     <= HELD;
          end else begin
            db_cnt_q <= db_cnt_q + DBW'(1);
          end
        end

        HELD: begin
          if (cs_q == 4'hF) begin
            db_cnt_q <= '0;
            state_q  <= RELEASE_DB;
          end
        end

        RELEASE_DB: begin
          if (cs_q != 4'hF) begin
            state_q <= HELD;
          end else if (db_cnt_q == DB_LAST) begin
            db_cnt_q   <= '0;
            scan_cnt_q <= '0;
            row_idx_q  <= row_idx_q + 2'd1;
            row_q      <= row_drive(row_idx_q + 2'd1);
            state_q    <= SCAN;
          end else begin
            db_cnt_q <= db_cnt_q + DBW'(1);
          end
        end

        default: state_q <= SCAN;
      endcase
    end
  end

  assign kp.row       = row_q;
  assign kp.digit_old = digit_old_q;
  assign kp.digit_new = digit_new_q;
  assign kp.key_pulse = key_pulse_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad matrix model, digit-pair scoreboard, randomized key activity.
module tb_keypad_scanner;
  localparam int SC = 8;
  localparam int DB = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  keypad_scanner_if kif ();

  keypad_scanner #(
    .SCAN_COUNT     (SC),
    .DEBOUNCE_COUNT (DB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .kp    (kif)
  );

  // Key index = row*4 + col; a pressed key pulls its column low only while its row is driven.
  function automatic logic [3:0] kp_cols(input logic [15:0] p, input logic [3:0] rw);
    logic [3:0] c;
    c = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 4; k++)
        if (p[r*4+k] && !rw[r]) c[k] = 1'b0;
    return c;
  endfunction

  logic [15:0] pressed = '0;
  logic        force_en = 1'b0;
  logic [3:0]  force_col = 4'hF;
  assign kif.col = force_en ? force_col : kp_cols(pressed, kif.row);

  logic [3:0] keymap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                              4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC,
                              4'hE, 4'h0, 4'hF, 4'hD};

  logic [7:0] sb_q [$];
  logic [3:0] m_old = 4'h0;
  logic [3:0] m_new = 4'h0;
  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int pulse_cnt = 0;
  int last_pulse_cyc = -1;
  int row_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_key(input int k);
    m_old = m_new;
    m_new = keymap[k];
    sb_q.push_back({m_old, m_new});
  endtask

  task monitor_loop();
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if ($countones(~kif.row) != 1) row_bad++;
      if (kif.key_pulse) begin
        pulse_cnt++;
        last_pulse_cyc = cyc;
        if (sb_q.size() == 0) begin
          chk("unexpected_pulse", {31'd0, kif.key_pulse}, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("digit_pair", {24'd0, kif.digit_old, kif.digit_new}, {24'd0, e});
        end
      end
    end
  endtask

  task automatic wait_row_entry(input logic [3:0] target);
    logic [3:0] prev;
    bit found;
    found = 1'b0;
    prev = kif.row;
    for (int i = 0; i < 80 && !found; i++) begin
      cycles(1);
      if (kif.row == target && prev != target) found = 1'b1;
      prev = kif.row;
    end
    if (!found) chk("row_entry_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_resume(input string name);
    logic [3:0] r0;
    cycles(5);
    r0 = kif.row;
    cycles(9);
    chk(name, {31'd0, kif.row != r0}, 32'd1);
  endtask

  initial begin
    int press_cyc, pc, bad, kind, k, r, c1, c2;
    fork
      monitor_loop();
    join_none

    reset = 1'b1;
    cycles(3);
    reset = 1'b0;
    chk("reset_row", {28'd0, kif.row}, 32'h0000000E);
    chk("reset_digits", {24'd0, kif.digit_old, kif.digit_new}, 32'd0);
    chk("reset_pulse", {31'd0, kif.key_pulse}, 32'd0);

    // Idle scan: the row advances every SC cycles after reset release.
    for (int t = 0; t < 40; t++) begin
      chk("scan_row", {28'd0, kif.row}, {28'd0, ~(4'b0001 << ((t / SC) % 4))});
      cycles(1);
    end

    // Key 5 pressed right as row 1 is driven: accept after DB+3 edges.
    wait_row_entry(4'b1101);
    pressed = 16'h1 << 5;
    press_cyc = cyc;
    expect_key(5);
    cycles(25);
    chk("press_latency", last_pulse_cyc - press_cyc, 32'd19);
    chk("pending_key5", sb_q.size(), 32'd0);
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      if (kif.row != 4'b1101) bad++;
      cycles(1);
    end
    chk("row_frozen_held", bad, 32'd0);
    pressed = '0;
    bad = 0;
    for (int i = 1; i <= 19; i++) begin
      cycles(1);
      if (i < 19 && kif.row != 4'b1101) bad++;
    end
    chk("row_frozen_release", bad, 32'd0);
    chk("row_after_release", {28'd0, kif.row}, 32'h0000000B);

    // Key 0 then key A.
    pressed = 16'h1 << 13;
    expect_key(13);
    cycles(70);
    pressed = '0;
    cycles(40);
    chk("pending_key0", sb_q.size(), 32'd0);
    pressed = 16'h1 << 3;
    expect_key(3);
    cycles(70);
    pressed = '0;
    cycles(40);
    chk("pending_keyA", sb_q.size(), 32'd0);
    chk("digits_after_A", {24'd0, kif.digit_old, kif.digit_new}, {24'd0, m_old, m_new});

    // Contact bounce every 3 cycles, then a solid hold: exactly one accept.
    pc = pulse_cnt;
    for (int i = 0; i < 40; i++) begin
      pressed = (((i / 3) % 2) == 0) ? (16'h1 << 10) : 16'h0;
      cycles(1);
    end
    pressed = 16'h1 << 10;
    expect_key(10);
    cycles(70);
    pressed = '0;
    cycles(40);
    chk("bounce_one_pulse", pulse_cnt - pc, 32'd1);
    chk("pending_bounce", sb_q.size(), 32'd0);

    // Short raw glitch and a two-column press: neither is accepted.
    pc = pulse_cnt;
    force_en = 1'b1;
    force_col = 4'b1110;
    cycles(10);
    force_en = 1'b0;
    check_resume("resume_after_glitch");
    force_en = 1'b1;
    force_col = 4'b1010;
    cycles(40);
    force_en = 1'b0;
    check_resume("resume_after_two_cols");
    chk("no_pulse_glitch", pulse_cnt - pc, 32'd0);

    // Randomized activity against the digit-history model.
    for (int it = 0; it < 14; it++) begin
      kind = $urandom_range(0, 2);
      k = $urandom_range(0, 15);
      case (kind)
        0: begin
          pressed = 16'h1 << k;
          expect_key(k);
          cycles($urandom_range(70, 90));
        end
        1: begin
          pressed = 16'h1 << k;
          cycles($urandom_range(1, 12));
        end
        default: begin
          r = $urandom_range(0, 3);
          c1 = $urandom_range(0, 3);
          c2 = (c1 + 1 + $urandom_range(0, 2)) % 4;
          pressed = (16'h1 << (r * 4 + c1)) | (16'h1 << (r * 4 + c2));
          cycles(40);
        end
      endcase
      pressed = '0;
      cycles(40);
      chk("pending_random", sb_q.size(), 32'd0);
      chk("digits_random", {24'd0, kif.digit_old, kif.digit_new}, {24'd0, m_old, m_new});
    end

    // Reset while HELD clears digits; the later release produces nothing.
    pressed = 16'h1 << 6;
    expect_key(6);
    cycles(70);
    chk("pending_before_reset", sb_q.size(), 32'd0);
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
    pressed = '0;
    m_old = 4'h0;
    m_new = 4'h0;
    chk("held_reset_row", {28'd0, kif.row}, 32'h0000000E);
    chk("held_reset_digits", {24'd0, kif.digit_old, kif.digit_new}, 32'd0);
    chk("held_reset_pulse", {31'd0, kif.key_pulse}, 32'd0);
    pc = pulse_cnt;
    cycles(60);
    chk("no_pulse_after_reset", pulse_cnt - pc, 32'd0);
    chk("digits_after_reset", {24'd0, kif.digit_old, kif.digit_new}, 32'd0);

    chk("row_one_hot", row_bad, 32'd0);
    chk("scoreboard_empty", sb_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 matrix keypad, debounces presses and releases, and keeps the two most recently entered hex digits for the dual seven-segment multiplexer. It drives the keypad rows and samples the raw column lines. It registers one new digit per debounced press, however long the key is held. `digit_old` and `digit_new` connect directly to the multiplexer's left and right digit inputs.

## Interface
- `SCAN_COUNT`, default 1_000: cycles each row is driven while scanning; must be ≥ 4.
- `DEBOUNCE_COUNT`, default 500_000: consecutive stable cycles (~10 ms at 48 MHz) needed to accept a press or a release; must be ≥ 1.
- `clk`  in  1  system clock; the block's only clock.
- `reset`  in  1  synchronous, active-high reset.
- `col`  in  4  raw keypad columns, active-low (pulled up), asynchronous to `clk`.
- `row`  out  4  row drive, active-low, exactly one bit low at all times.
- `digit_old`  out  4  previously accepted digit (left display).
- `digit_new`  out  4  most recently accepted digit (right display).
- `key_pulse`  out  1  one-cycle strobe, high in the cycle `digit_new` first shows a new digit.

## Operation
- `col` passes through a 2-flop synchronizer. The FSM sees only the synchronized value `cs`.
- Key map, listed as row r, columns 0..3:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: E 0 F D
- `row` = ~(1 << `row_idx`).
- FSM states: SCAN, PRESS_DB, HELD, RELEASE_DB.
- **SCAN**
  - `scan_cnt` counts 0..SCAN_COUNT-1.
  - At terminal count: `row_idx` increments (3 wraps to 0) and `scan_cnt` clears.
  - Columns are checked only while `scan_cnt` ≥ 2, because the synchronizer still carries the previous row below that.
  - If `cs` has exactly one bit low: latch `row_idx` and `cs` as the key, clear `db_cnt`, go to PRESS_DB.
  - If `cs` has zero or two or more bits low: keep scanning.
- **PRESS_DB**
  - `row` is frozen.
  - If `cs` ≠ latched pattern: return to SCAN; `db_cnt` clears and `scan_cnt` resumes from 0 on the same row.
  - If `cs` = latched pattern and `db_cnt` = DEBOUNCE_COUNT-1: go to HELD and, on the same edge:
    - `digit_old` ← `digit_new`
    - `digit_new` ← decoded key
    - `key_pulse` ← 1
  - Otherwise `db_cnt` increments.
- **HELD**
  - `row` stays frozen and no new digits are accepted, including extra columns going low.
  - When `cs` = 4'hF: clear `db_cnt`, go to RELEASE_DB.
- **RELEASE_DB**
  - If `cs` ≠ 4'hF: return to HELD.
  - At `db_cnt` = DEBOUNCE_COUNT-1 with `cs` = 4'hF: go to SCAN, advance `row_idx`, clear `scan_cnt`.
  - Otherwise `db_cnt` increments.
- Counters are sized with $clog2 of their parameter. The FSM never runs a counter past its terminal count.

## Timing
- Reset values:
  - state SCAN, `row_idx` 0, so `row` = 4'b1110
  - `scan_cnt` and `db_cnt` = 0
  - synchronizer flops = 4'hF
  - `digit_old`, `digit_new` = 0; `key_pulse` = 0
- A reset asserted at any point (mid-debounce, HELD, RELEASE_DB) takes effect at the next edge and clears the stored digits.
- Every output comes straight from a register; none are combinational.
- Press latency: with the matching row already driven, `scan_cnt` ≥ 2, and `col` low before edge 1:
  - edge 2: the low is visible on `cs`
  - edge 3: FSM enters PRESS_DB
  - edge N+3: the digit updates and `key_pulse` rises (N = DEBOUNCE_COUNT)
  - `key_pulse` falls at edge N+4.
- Release latency: at least DEBOUNCE_COUNT + 3 cycles from the raw release before scanning resumes.
- Simultaneous reset and a press-accept condition: reset wins; no pulse and no digit update.

## Test plan
Use SCAN_COUNT=8 and DEBOUNCE_COUNT=16 throughout.
- Reset, `col` = F for 40 cycles -> `row` 1110→1101→1011→0111→1110, changing every 8 cycles; digits 0; `key_pulse` never high.
- Hold key 5 (row 1, col 1 low while `row[1]`=0) -> `key_pulse` exactly once, 19 cycles after the sampling edge; `digit_new`=5, `digit_old`=0; `row` stays 1101 until release + ≥19 cycles.
- Press 0, release, then press A -> after 0: old=5, new=0; after A: old=0, new=A; one pulse per press.
- Column bounces low/high every 3 cycles for 40 cycles, then stays low -> exactly one pulse, digit correct.
- Low glitch of 10 cycles, and separately two columns low together -> no pulse, scanning resumes.
- Reset asserted during HELD -> next cycle: SCAN, `row`=1110, both digits 0, and no pulse on the later release.
